// File: rtl/reg_file_core.sv
// Register file with 2**ADDR_WIDTH entries, two combinational read ports and one
// synchronous write-back port. Register 0 reads as zero and ignores writes.
module reg_file_core #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  rwb_we,
  input  logic [ADDR_WIDTH-1:0] rwb_addr,
  input  logic [WIDTH-1:0]      rwb_data,
  output logic [WIDTH-1:0]      rs1_out,
  output logic [WIDTH-1:0]      rs2_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      ZERO_DATA = {WIDTH{1'b0}};

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic             wr_en_s;
  logic [WIDTH-1:0] rs1_s;
  logic [WIDTH-1:0] rs2_s;

  // Writes to entry 0 are dropped so the hardwired zero never has to be masked on storage.
  always_comb begin
    wr_en_s = 1'b0;
    if (rwb_we && (rwb_addr != ZERO_ADDR)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array: asynchronous clear, full-width write on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else if (wr_en_s) begin
      regs_r[rwb_addr] <= rwb_data;
    end
  end

  // Read ports see stored contents only; a same-cycle write is visible after the edge.
  always_comb begin
    rs1_s = ZERO_DATA;
    rs2_s = ZERO_DATA;
    if (rs1_addr == ZERO_ADDR) begin
      rs1_s = ZERO_DATA;
    end else begin
      rs1_s = regs_r[rs1_addr];
    end
    if (rs2_addr == ZERO_ADDR) begin
      rs2_s = ZERO_DATA;
    end else begin
      rs2_s = regs_r[rs2_addr];
    end
  end

  assign rs1_out = rs1_s;
  assign rs2_out = rs2_s;

endmodule

// File: tb/tb_reg_file_core.sv
// Directed bench for reg_file_core with ADDR_WIDTH=4, WIDTH=8.
module tb_reg_file_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] rs1_addr;
  logic [3:0] rs2_addr;
  logic       rwb_we;
  logic [3:0] rwb_addr;
  logic [7:0] rwb_data;
  logic [7:0] rs1_out;
  logic [7:0] rs2_out;

  int errors = 0;
  int checks = 0;

  reg_file_core #(.ADDR_WIDTH(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rwb_we   (rwb_we),
    .rwb_addr (rwb_addr),
    .rwb_data (rwb_data),
    .rs1_out  (rs1_out),
    .rs2_out  (rs2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rwb_we   = 1'b1;
    rwb_addr = a;
    rwb_data = d;
    @(negedge clk);
    rwb_we   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rs1_addr = 4'd0;
    rs2_addr = 4'd0;
    rwb_we   = 1'b0;
    rwb_addr = 4'd0;
    rwb_data = 8'h00;

    // Reset: every address reads zero, writes ignored.
    #2;
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i);
      rs2_addr = 4'(15 - i);
      #1;
      check("reset_rs1", rs1_out, 8'h00);
      check("reset_rs2", rs2_out, 8'h00);
    end
    rwb_we   = 1'b1;
    rwb_addr = 4'd2;
    rwb_data = 8'hFF;
    rs1_addr = 4'd2;
    @(posedge clk); #1;
    check("write_in_reset", rs1_out, 8'h00);
    rwb_we = 1'b0;

    // First write after reset release lands on the first edge.
    @(negedge clk);
    rst_n    = 1'b1;
    rwb_we   = 1'b1;
    rwb_addr = 4'd6;
    rwb_data = 8'h66;
    rs1_addr = 4'd6;
    #1;
    check("first_write_before", rs1_out, 8'h00);
    @(posedge clk); #1;
    check("first_write_after", rs1_out, 8'h66);
    @(negedge clk);
    rwb_we = 1'b0;

    // Fill 1..15 with 10..150, then try to write address 0.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      rwb_we   = 1'b1;
      rwb_addr = 4'(i);
      rwb_data = 8'(i * 10);
    end
    @(negedge clk);
    rwb_addr = 4'd0;
    rwb_data = 8'd160;
    @(negedge clk);
    rwb_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i);
      rs2_addr = 4'(15 - i);
      #1;
      check("sweep_rs1", rs1_out, 8'(i * 10));
      check("sweep_rs2", rs2_out, 8'((15 - i) * 10));
    end

    // Disabled write holds contents.
    @(negedge clk);
    rwb_we   = 1'b0;
    rwb_addr = 4'd5;
    rwb_data = 8'hAA;
    rs1_addr = 4'd5;
    repeat (3) @(negedge clk);
    check("we_low_hold", rs1_out, 8'd50);

    // No forwarding: old value before the edge, new after; held write is idempotent.
    write_reg(4'd3, 8'h30);
    rs1_addr = 4'd3;
    rwb_we   = 1'b1;
    rwb_addr = 4'd3;
    rwb_data = 8'h55;
    #1;
    check("no_fwd_before", rs1_out, 8'h30);
    @(posedge clk); #1;
    check("no_fwd_after", rs1_out, 8'h55);
    @(posedge clk); #1;
    check("held_write", rs1_out, 8'h55);
    @(negedge clk);
    rwb_we = 1'b0;

    // Both ports on one register.
    write_reg(4'd7, 8'h70);
    rs1_addr = 4'd7;
    rs2_addr = 4'd7;
    #1;
    check("same_addr_rs1", rs1_out, 8'h70);
    check("same_addr_rs2", rs2_out, 8'h70);

    // Mid-cycle reset clears immediately.
    rs2_addr = 4'd15;
    #1;
    check("pre_reset_rs2", rs2_out, 8'd150);
    rst_n = 1'b0;
    #1;
    check("async_reset_rs1", rs1_out, 8'h00);
    check("async_reset_rs2", rs2_out, 8'h00);
    for (int i = 1; i < 16; i++) begin
      rs1_addr = 4'(i);
      #1;
      check("async_reset_sweep", rs1_out, 8'h00);
    end

    // Reset coincident with a write edge loses the write.
    @(negedge clk);
    rst_n = 1'b1;
    write_reg(4'd9, 8'h99);
    rs1_addr = 4'd9;
    rs2_addr = 4'd4;
    #1;
    check("pre_coincident", rs1_out, 8'h99);
    rwb_we   = 1'b1;
    rwb_addr = 4'd4;
    rwb_data = 8'h44;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("coincident_rs1", rs1_out, 8'h00);
    check("coincident_rs2", rs2_out, 8'h00);
    rwb_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_coincident", rs2_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
